// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-keeping and time-setting controller for the digital clock.
// Divides the system clock down to a 1 s tick and keeps HH:MM:SS in BCD.
// A RUN / SET_HOUR / SET_MIN mode machine is stepped by three debounced buttons.
// It also produces blanking strobes that blink the field being edited.
module clock_set_ctrl #(
    parameter int SEC1_MAX  = 125000000,
    parameter int BLINK_MAX = 62500000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_MODE,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    output logic [1:0] HOUR10,
    output logic [3:0] HOUR1,
    output logic [2:0] MIN10,
    output logic [3:0] MIN1,
    output logic [2:0] SEC10,
    output logic [3:0] SEC1,
    output logic [1:0] MODE,
    output logic       BLANK_HOUR,
    output logic       BLANK_MIN,
    output logic       SEC_TICK
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_t;

    mode_t       state;
    mode_t       state_next;

    logic        mode_q;
    logic        up_q;
    logic        down_q;
    logic        mode_pulse;
    logic        up_pulse;
    logic        down_pulse;
    logic        edit_up;
    logic        edit_down;
    logic        edit_accepted;

    logic [26:0] prescaler;
    logic        tick;

    logic [25:0] blink_cnt;
    logic        blink_phase;

    logic [1:0]  hour10_next;
    logic [3:0]  hour1_next;
    logic [2:0]  min10_next;
    logic [3:0]  min1_next;
    logic [2:0]  sec10_next;
    logic [3:0]  sec1_next;

    // Hours plus one, 23 wraps to 00; the units carry into the tens only below 20.
    function automatic logic [5:0] hour_inc(input logic [1:0] h10, input logic [3:0] h1);
        if (h10 == 2'd2 && h1 == 4'd3)
            return 6'd0;
        else if (h1 == 4'd9)
            return {h10 + 2'd1, 4'd0};
        else
            return {h10, h1 + 4'd1};
    endfunction

    // Hours minus one, 00 wraps to 23.
    function automatic logic [5:0] hour_dec(input logic [1:0] h10, input logic [3:0] h1);
        if (h10 == 2'd0 && h1 == 4'd0)
            return {2'd2, 4'd3};
        else if (h1 == 4'd0)
            return {h10 - 2'd1, 4'd9};
        else
            return {h10, h1 - 4'd1};
    endfunction

    // Minutes plus one, 59 wraps to 00; any carry into hours is handled by the caller.
    function automatic logic [6:0] min_inc(input logic [2:0] m10, input logic [3:0] m1);
        if (m1 == 4'd9) begin
            if (m10 == 3'd5)
                return 7'd0;
            else
                return {m10 + 3'd1, 4'd0};
        end else begin
            return {m10, m1 + 4'd1};
        end
    endfunction

    // Minutes minus one, 00 wraps to 59 with no borrow from hours.
    function automatic logic [6:0] min_dec(input logic [2:0] m10, input logic [3:0] m1);
        if (m10 == 3'd0 && m1 == 4'd0)
            return {3'd5, 4'd9};
        else if (m1 == 4'd0)
            return {m10 - 3'd1, 4'd9};
        else
            return {m10, m1 - 4'd1};
    endfunction

    assign mode_pulse    = BTN_MODE & ~mode_q;
    assign up_pulse      = BTN_UP & ~up_q;
    assign down_pulse    = BTN_DOWN & ~down_q;
    assign edit_up       = up_pulse & ~down_pulse & ~mode_pulse;
    assign edit_down     = down_pulse & ~up_pulse & ~mode_pulse;
    assign edit_accepted = (state != RUN) & (edit_up | edit_down);

    assign tick       = (state == RUN) && (prescaler == 27'(SEC1_MAX - 1));
    assign SEC_TICK   = tick;
    assign MODE       = state;
    assign BLANK_HOUR = (state == SET_HOUR) & blink_phase;
    assign BLANK_MIN  = (state == SET_MIN) & blink_phase;

    // Button history starts high so a button held through reset release does not fire.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mode_q <= 1'b1;
            up_q   <= 1'b1;
            down_q <= 1'b1;
        end else begin
            mode_q <= BTN_MODE;
            up_q   <= BTN_UP;
            down_q <= BTN_DOWN;
        end
    end

    // Mode state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= RUN;
        else
            state <= state_next;
    end

    // Each MODE pulse steps RUN -> SET_HOUR -> SET_MIN -> RUN.
    always_comb begin
        state_next = state;
        if (mode_pulse) begin
            case (state)
                RUN:      state_next = SET_HOUR;
                SET_HOUR: state_next = SET_MIN;
                SET_MIN:  state_next = RUN;
                default:  state_next = RUN;
            endcase
        end
    end

    // Prescaler only counts while staying in RUN, so leaving or re-entering RUN restarts the second.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            prescaler <= 27'd0;
        else if (state == RUN && state_next == RUN && !tick)
            prescaler <= prescaler + 27'd1;
        else
            prescaler <= 27'd0;
    end

    // Next time value: ticking carry chain in RUN, single-field edits in the SET modes.
    always_comb begin
        hour10_next = HOUR10;
        hour1_next  = HOUR1;
        min10_next  = MIN10;
        min1_next   = MIN1;
        sec10_next  = SEC10;
        sec1_next   = SEC1;
        case (state)
            RUN: begin
                if (tick) begin
                    if (SEC1 != 4'd9) begin
                        sec1_next = SEC1 + 4'd1;
                    end else if (SEC10 != 3'd5) begin
                        sec1_next  = 4'd0;
                        sec10_next = SEC10 + 3'd1;
                    end else begin
                        sec1_next  = 4'd0;
                        sec10_next = 3'd0;
                        {min10_next, min1_next} = min_inc(MIN10, MIN1);
                        if (MIN10 == 3'd5 && MIN1 == 4'd9)
                            {hour10_next, hour1_next} = hour_inc(HOUR10, HOUR1);
                    end
                end
                if (mode_pulse) begin
                    sec10_next = 3'd0;
                    sec1_next  = 4'd0;
                end
            end
            SET_HOUR: begin
                if (edit_up)
                    {hour10_next, hour1_next} = hour_inc(HOUR10, HOUR1);
                else if (edit_down)
                    {hour10_next, hour1_next} = hour_dec(HOUR10, HOUR1);
            end
            SET_MIN: begin
                if (edit_up)
                    {min10_next, min1_next} = min_inc(MIN10, MIN1);
                else if (edit_down)
                    {min10_next, min1_next} = min_dec(MIN10, MIN1);
            end
            default: ;
        endcase
    end

    // Time digit registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            HOUR10 <= 2'd0;
            HOUR1  <= 4'd0;
            MIN10  <= 3'd0;
            MIN1   <= 4'd0;
            SEC10  <= 3'd0;
            SEC1   <= 4'd0;
        end else begin
            HOUR10 <= hour10_next;
            HOUR1  <= hour1_next;
            MIN10  <= min10_next;
            MIN1   <= min1_next;
            SEC10  <= sec10_next;
            SEC1   <= sec1_next;
        end
    end

    // Blink timer restarts on mode changes and edits so the edited digits show at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            blink_cnt   <= 26'd0;
            blink_phase <= 1'b0;
        end else if (state == RUN || state_next != state || edit_accepted) begin
            blink_cnt   <= 26'd0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == 26'(BLINK_MAX - 1)) begin
            blink_cnt   <= 26'd0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 26'd1;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed bench for clock_set_ctrl with a short second and blink period.
// Stimulus pushes hand-computed expectations into a queue.
// A monitor on the falling clock edge pops and compares them against the DUT outputs.
module tb_clock_set_ctrl;

    localparam int SEC1_MAX  = 4;
    localparam int BLINK_MAX = 3;

    typedef enum int {SEL_TIME, SEL_MODE, SEL_BLANK_HOUR, SEL_BLANK_MIN, SEL_TICK} sel_t;

    typedef struct {
        string       name;
        sel_t        sel;
        logic [19:0] value;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [1:0] hour10;
    logic [3:0] hour1;
    logic [2:0] min10;
    logic [3:0] min1;
    logic [2:0] sec10;
    logic [3:0] sec1;
    logic [1:0] mode;
    logic       blank_hour;
    logic       blank_min;
    logic       sec_tick;

    exp_t exp_q[$];
    int   total_checks = 0;
    int   bad_checks = 0;

    clock_set_ctrl #(
        .SEC1_MAX (SEC1_MAX),
        .BLINK_MAX(BLINK_MAX)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .BTN_MODE  (btn_mode),
        .BTN_UP    (btn_up),
        .BTN_DOWN  (btn_down),
        .HOUR10    (hour10),
        .HOUR1     (hour1),
        .MIN10     (min10),
        .MIN1      (min1),
        .SEC10     (sec10),
        .SEC1      (sec1),
        .MODE      (mode),
        .BLANK_HOUR(blank_hour),
        .BLANK_MIN (blank_min),
        .SEC_TICK  (sec_tick)
    );

    // Free-running 100 MHz system clock.
    always #5 clk = ~clk;

    function automatic logic [19:0] pack_time(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [19:0] actual_of(input sel_t sel);
        case (sel)
            SEL_TIME:       return {hour10, hour1, min10, min1, sec10, sec1};
            SEL_MODE:       return 20'(mode);
            SEL_BLANK_HOUR: return 20'(blank_hour);
            SEL_BLANK_MIN:  return 20'(blank_min);
            default:        return 20'(sec_tick);
        endcase
    endfunction

    task automatic checkOutput(input string name, input sel_t sel, input logic [19:0] value);
        exp_t e;
        e.name  = name;
        e.sel   = sel;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic expect_time(input string name, input int h, input int m, input int s);
        checkOutput(name, SEL_TIME, pack_time(h, m, s));
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic m, input logic u, input logic d);
        btn_mode = m;
        btn_up   = u;
        btn_down = d;
        step_cycle();
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
    endtask

    // Scoreboard monitor: compares every queued expectation against the settled outputs.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [19:0] act;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = actual_of(e.sel);
            total_checks++;
            if (act !== e.value) begin
                bad_checks++;
                $display("[TB] FAIL %s: got %h, expected %h", e.name, act, e.value);
            end
        end
    end

    // Directed scenario.
    initial begin
        repeat (2) step_cycle();
        expect_time("reset_time", 0, 0, 0);
        checkOutput("reset_mode", SEL_MODE, 20'd0);
        checkOutput("reset_blank_hour", SEL_BLANK_HOUR, 20'd0);
        checkOutput("reset_blank_min", SEL_BLANK_MIN, 20'd0);
        checkOutput("reset_tick", SEL_TICK, 20'd0);

        // Release reset with MODE held high; the first tick arrives in the 4th cycle.
        rst = 1'b0;
        checkOutput("rel_tick0", SEL_TICK, 20'd0);
        step_cycle();
        checkOutput("rel_tick1", SEL_TICK, 20'd0);
        step_cycle();
        checkOutput("rel_tick2", SEL_TICK, 20'd0);
        step_cycle();
        checkOutput("rel_tick3", SEL_TICK, 20'd1);
        expect_time("rel_time_before_tick", 0, 0, 0);
        step_cycle();
        checkOutput("rel_tick_after", SEL_TICK, 20'd0);
        expect_time("rel_first_second", 0, 0, 1);
        checkOutput("held_mode_no_pulse", SEL_MODE, 20'd0);
        btn_mode = 1'b0;
        step_cycle();

        // Edits in SET_HOUR and SET_MIN, including wraps and conflicting presses.
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("enter_set_hour", SEL_MODE, 20'd1);
        expect_time("enter_set_hour_time", 0, 0, 0);
        step_cycle();
        applyStimulus(1'b0, 1'b0, 1'b1);
        expect_time("hour_down_wrap", 23, 0, 0);
        step_cycle();
        applyStimulus(1'b0, 1'b1, 1'b0);
        expect_time("hour_up_wrap", 0, 0, 0);
        step_cycle();
        applyStimulus(1'b0, 1'b0, 1'b1);
        expect_time("hour_down_again", 23, 0, 0);
        step_cycle();
        applyStimulus(1'b0, 1'b1, 1'b1);
        expect_time("up_down_discarded", 23, 0, 0);
        step_cycle();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("mode_up_mode", SEL_MODE, 20'd2);
        expect_time("mode_up_hours_kept", 23, 0, 0);
        step_cycle();
        applyStimulus(1'b0, 1'b0, 1'b1);
        expect_time("min_down_wrap", 23, 59, 0);
        step_cycle();
        applyStimulus(1'b0, 1'b1, 1'b0);
        expect_time("min_up_wrap_no_carry", 23, 0, 0);
        step_cycle();
        applyStimulus(1'b0, 1'b0, 1'b1);
        expect_time("min_down_to_59", 23, 59, 0);
        step_cycle();

        // Back to RUN: first tick exactly SEC1_MAX cycles after the transition edge.
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("back_to_run", SEL_MODE, 20'd0);
        checkOutput("run_tick_c0", SEL_TICK, 20'd0);
        expect_time("run_start_time", 23, 59, 0);
        step_cycle();
        checkOutput("run_tick_c1", SEL_TICK, 20'd0);
        step_cycle();
        checkOutput("run_tick_c2", SEL_TICK, 20'd0);
        step_cycle();
        checkOutput("run_tick_c3", SEL_TICK, 20'd1);
        step_cycle();
        expect_time("run_first_second", 23, 59, 1);
        repeat (228) step_cycle();
        expect_time("preload_58", 23, 59, 58);
        repeat (3) step_cycle();
        checkOutput("tick_at_58", SEL_TICK, 20'd1);
        step_cycle();
        expect_time("time_59", 23, 59, 59);
        checkOutput("tick_off_59", SEL_TICK, 20'd0);
        repeat (3) step_cycle();
        checkOutput("tick_at_59", SEL_TICK, 20'd1);
        expect_time("still_59", 23, 59, 59);
        step_cycle();
        expect_time("day_rollover", 0, 0, 0);
        checkOutput("tick_off_rollover", SEL_TICK, 20'd0);

        // MODE pressed in the tick cycle at 00:00:07: seconds clear instead of advancing.
        repeat (31) step_cycle();
        checkOutput("tick_at_07", SEL_TICK, 20'd1);
        expect_time("time_07", 0, 0, 7);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("tick_mode_set_hour", SEL_MODE, 20'd1);
        expect_time("tick_mode_sec_clear", 0, 0, 0);
        checkOutput("set_hour_blank_min", SEL_BLANK_MIN, 20'd0);

        // Frozen time and blink pattern while in SET_HOUR.
        for (int k = 0; k <= 22; k++) begin
            if (k > 0) step_cycle();
            checkOutput("blank_hour_seq", SEL_BLANK_HOUR, 20'((k / 3) % 2));
            checkOutput("set_no_tick", SEL_TICK, 20'd0);
            expect_time("set_frozen", 0, 0, 0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        expect_time("hour_up_in_blink", 1, 0, 0);
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) step_cycle();
            checkOutput("blank_restart_seq", SEL_BLANK_HOUR, 20'((k / 3) % 2));
        end

        // Set 12:34 then reset mid-edit in SET_MIN while the minutes are blanked.
        for (int i = 0; i < 11; i++) begin
            step_cycle();
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        expect_time("hours_12", 12, 0, 0);
        step_cycle();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("enter_set_min", SEL_MODE, 20'd2);
        for (int i = 0; i < 34; i++) begin
            step_cycle();
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        expect_time("time_12_34", 12, 34, 0);
        checkOutput("blank_min_after_edit", SEL_BLANK_MIN, 20'd0);
        repeat (3) step_cycle();
        checkOutput("blank_min_on", SEL_BLANK_MIN, 20'd1);
        checkOutput("blank_hour_in_set_min", SEL_BLANK_HOUR, 20'd0);
        step_cycle();
        #2;
        rst = 1'b1;
        expect_time("async_reset_time", 0, 0, 0);
        checkOutput("async_reset_mode", SEL_MODE, 20'd0);
        checkOutput("async_reset_blank_min", SEL_BLANK_MIN, 20'd0);
        step_cycle();
        expect_time("held_reset_time", 0, 0, 0);
        rst = 1'b0;

        repeat (2) step_cycle();
        total_checks++;
        if (exp_q.size() != 0) begin
            bad_checks++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
